// File: rtl/msrh_stq_pq.sv
// msrh_stq_pq: parametrised store queue for the MSRH LSU.
//   Allocates up to DISP_W stores per cycle in program order. Captures address
//   and data from PIPE_N LSU pipes. Commits the oldest entries, and flushes
//   uncommitted ones. Drains committed stores in order to the L1D, replaying a
//   store after a miss refill.
// Ports:
//   i_clk, i_reset_n          clock, asynchronous active-low reset
//   i_disp_*/o_disp_*         allocation requests, ready and assigned indices
//   i_ex_*                    address/data capture per pipe
//   o_done_*                  completion report, one cycle after capture
//   i_commit_num, i_flush     retirement control
//   o_l1d_req_*, i_l1d_*      L1D write handshake
//   i_refill_done             miss refill complete pulse
//   o_empty                   no valid entries
// Optional build macro MSRH_STQ_PERF_CNT_EN adds o_perf_drain_cnt and
// o_perf_miss_cnt (32-bit saturating).
//
// Drain FSM
//   state    | meaning
//   D_IDLE   | waiting for entry[drain_ptr] to be COMMIT
//   D_REQ    | request valid, payload held until accepted
//   D_RESP   | request accepted, waiting for the L1D response
//   D_REFILL | miss reported, waiting for the refill to finish before replay
module msrh_stq_pq #(
   parameter int STQ_SIZE  = 16,
   parameter int DISP_W    = 2,
   parameter int PIPE_N    = 2,
   parameter int TAG_W     = 8,
   parameter int PADDR_W   = 56,
   parameter int XLEN_W    = 64,
   parameter int DC_DATA_W = 128,
   localparam int IDX_W    = $clog2(STQ_SIZE),
   localparam int CMT_W    = $clog2(DISP_W) + 1,
   localparam int BE_W     = DC_DATA_W / 8
) (
   input  logic                              i_clk,
   input  logic                              i_reset_n,
   input  logic [DISP_W-1:0]                 i_disp_valid,
   input  logic [DISP_W-1:0][TAG_W-1:0]      i_disp_tag,
   output logic                              o_disp_ready,
   output logic [DISP_W-1:0][IDX_W-1:0]      o_disp_idx,
   input  logic [PIPE_N-1:0]                 i_ex_valid,
   input  logic [PIPE_N-1:0][IDX_W-1:0]      i_ex_idx,
   input  logic [PIPE_N-1:0][PADDR_W-1:0]    i_ex_paddr,
   input  logic [PIPE_N-1:0][1:0]            i_ex_size,
   input  logic [PIPE_N-1:0][XLEN_W-1:0]     i_ex_data,
   output logic [PIPE_N-1:0]                 o_done_valid,
   output logic [PIPE_N-1:0][TAG_W-1:0]      o_done_tag,
   input  logic [CMT_W-1:0]                  i_commit_num,
   input  logic                              i_flush,
   output logic                              o_l1d_req_valid,
   input  logic                              i_l1d_req_ready,
   output logic [PADDR_W-1:0]                o_l1d_req_paddr,
   output logic [DC_DATA_W-1:0]              o_l1d_req_data,
   output logic [BE_W-1:0]                   o_l1d_req_be,
   input  logic                              i_l1d_resp_valid,
   input  logic                              i_l1d_resp_hit,
   input  logic                              i_refill_done,
   output logic                              o_empty
`ifdef MSRH_STQ_PERF_CNT_EN
   ,
   output logic [31:0]                       o_perf_drain_cnt,
   output logic [31:0]                       o_perf_miss_cnt
`endif
);

   localparam int CNT_W = IDX_W + 1;
   localparam int OFS_W = $clog2(BE_W);
   localparam int REP   = DC_DATA_W / XLEN_W;

   typedef enum logic [1:0] {E_FREE, E_WAIT, E_DONE, E_COMMIT} ent_st_t;
   typedef enum logic [1:0] {D_IDLE, D_REQ, D_RESP, D_REFILL} drn_st_t;

   ent_st_t             st_q [STQ_SIZE];
   ent_st_t             st_n [STQ_SIZE];
   logic [TAG_W-1:0]    tag_q   [STQ_SIZE];
   logic [PADDR_W-1:0]  paddr_q [STQ_SIZE];
   logic [1:0]          size_q  [STQ_SIZE];
   logic [XLEN_W-1:0]   data_q  [STQ_SIZE];

   logic [IDX_W-1:0]    alloc_ptr_q, alloc_ptr_n;
   logic [IDX_W-1:0]    cmt_ptr_q, cmt_ptr_n;
   logic [IDX_W-1:0]    drain_ptr_q, drain_ptr_n;
   logic [CNT_W-1:0]    occ_q, occ_n, n_alloc;
   drn_st_t             dst_q, dst_n;
   logic                do_alloc, drain_free, drain_miss;
   logic [PIPE_N-1:0]   ex_acc;

   assign o_disp_ready = (CNT_W'(STQ_SIZE) - occ_q) >= CNT_W'(DISP_W);
   assign o_empty      = (occ_q == '0);
   assign do_alloc     = o_disp_ready && !i_flush && (|i_disp_valid);
   assign drain_free   = (dst_q == D_RESP) && i_l1d_resp_valid && i_l1d_resp_hit;
   assign drain_miss   = (dst_q == D_RESP) && i_l1d_resp_valid && !i_l1d_resp_hit;

   always_comb begin
      for (int k = 0; k < DISP_W; k++) o_disp_idx[k] = alloc_ptr_q + IDX_W'(k);
   end

   // A pipe only captures into a WAIT entry; a lower pipe hitting the same
   // index takes priority.
   always_comb begin
      for (int p = 0; p < PIPE_N; p++) begin
         ex_acc[p] = i_ex_valid[p] && !i_flush && (st_q[i_ex_idx[p]] == E_WAIT);
         for (int q = 0; q < p; q++)
            if (i_ex_valid[q] && (i_ex_idx[q] == i_ex_idx[p])) ex_acc[p] = 1'b0;
      end
   end

   // Entry next state: drain free, allocate, capture, commit, then flush last
   // so it sees the post-commit state.
   always_comb begin
      for (int i = 0; i < STQ_SIZE; i++) st_n[i] = st_q[i];
      alloc_ptr_n = alloc_ptr_q;
      drain_ptr_n = drain_ptr_q;
      n_alloc     = '0;
      occ_n       = '0;
      if (drain_free) begin
         st_n[drain_ptr_q] = E_FREE;
         drain_ptr_n       = drain_ptr_q + IDX_W'(1);
      end
      for (int k = 0; k < DISP_W; k++) begin
         n_alloc = n_alloc + CNT_W'(i_disp_valid[k]);
         if (do_alloc && i_disp_valid[k]) st_n[alloc_ptr_q + IDX_W'(k)] = E_WAIT;
      end
      if (do_alloc) alloc_ptr_n = alloc_ptr_q + n_alloc[IDX_W-1:0];
      for (int p = 0; p < PIPE_N; p++)
         if (ex_acc[p]) st_n[i_ex_idx[p]] = E_DONE;
      for (int c = 0; c < DISP_W; c++)
         if (CMT_W'(c) < i_commit_num) st_n[cmt_ptr_q + IDX_W'(c)] = E_COMMIT;
      cmt_ptr_n = cmt_ptr_q + IDX_W'(i_commit_num);
      if (i_flush) begin
         for (int i = 0; i < STQ_SIZE; i++)
            if (st_n[i] == E_WAIT || st_n[i] == E_DONE) st_n[i] = E_FREE;
         alloc_ptr_n = cmt_ptr_n;
      end
      for (int i = 0; i < STQ_SIZE; i++)
         occ_n = occ_n + CNT_W'(st_n[i] != E_FREE);
   end

   always_comb begin
      dst_n = dst_q;
      case (dst_q)
         D_IDLE:   if (st_q[drain_ptr_q] == E_COMMIT) dst_n = D_REQ;
         D_REQ:    if (i_l1d_req_ready) dst_n = D_RESP;
         D_RESP:   if (i_l1d_resp_valid) dst_n = i_l1d_resp_hit ? D_IDLE : D_REFILL;
         D_REFILL: if (i_refill_done) dst_n = D_REQ;
         default:  dst_n = D_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int i = 0; i < STQ_SIZE; i++) st_q[i] <= E_FREE;
         alloc_ptr_q  <= '0;
         cmt_ptr_q    <= '0;
         drain_ptr_q  <= '0;
         occ_q        <= '0;
         dst_q        <= D_IDLE;
         o_done_valid <= '0;
         o_done_tag   <= '0;
      end else begin
         for (int i = 0; i < STQ_SIZE; i++) st_q[i] <= st_n[i];
         alloc_ptr_q  <= alloc_ptr_n;
         cmt_ptr_q    <= cmt_ptr_n;
         drain_ptr_q  <= drain_ptr_n;
         occ_q        <= occ_n;
         dst_q        <= dst_n;
         o_done_valid <= ex_acc;
         for (int p = 0; p < PIPE_N; p++)
            o_done_tag[p] <= ex_acc[p] ? tag_q[i_ex_idx[p]] : '0;
      end
   end

   // Payload storage needs no reset: it is only observed through valid states.
   always_ff @(posedge i_clk) begin
      for (int k = 0; k < DISP_W; k++)
         if (do_alloc && i_disp_valid[k]) tag_q[alloc_ptr_q + IDX_W'(k)] <= i_disp_tag[k];
      for (int p = 0; p < PIPE_N; p++)
         if (ex_acc[p]) begin
            paddr_q[i_ex_idx[p]] <= i_ex_paddr[p];
            size_q[i_ex_idx[p]]  <= i_ex_size[p];
            data_q[i_ex_idx[p]]  <= i_ex_data[p];
         end
   end

   logic [PADDR_W-1:0] dpa;
   logic [3:0]         nbytes;
   logic [XLEN_W-1:0]  dsh;

   assign dpa    = paddr_q[drain_ptr_q];
   assign nbytes = 4'(1) << size_q[drain_ptr_q];
   assign dsh    = data_q[drain_ptr_q] << {dpa[2:0], 3'b000};

   // Payload is driven only in REQ so idle outputs sit at zero.
   assign o_l1d_req_valid = (dst_q == D_REQ);
   assign o_l1d_req_paddr = o_l1d_req_valid ? {dpa[PADDR_W-1:OFS_W], OFS_W'(0)} : '0;
   assign o_l1d_req_data  = o_l1d_req_valid ? {REP{dsh}} : '0;
   assign o_l1d_req_be    = o_l1d_req_valid ?
                            (((BE_W'(1) << nbytes) - BE_W'(1)) << dpa[OFS_W-1:0]) : '0;

`ifdef MSRH_STQ_PERF_CNT_EN
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         o_perf_drain_cnt <= '0;
         o_perf_miss_cnt  <= '0;
      end else begin
         if (drain_free && (o_perf_drain_cnt != '1)) o_perf_drain_cnt <= o_perf_drain_cnt + 32'd1;
         if (drain_miss && (o_perf_miss_cnt != '1))  o_perf_miss_cnt  <= o_perf_miss_cnt + 32'd1;
      end
   end
`else
   logic unused_miss;
   assign unused_miss = drain_miss;
`endif

`ifndef SYNTHESIS
   always_ff @(posedge i_clk) begin
      if (i_reset_n) begin
         if ((|i_disp_valid) && !o_disp_ready)
            $fatal(1, "stq: allocation while not ready");
         for (int p = 0; p < PIPE_N; p++)
            for (int q = 0; q < p; q++)
               if (i_ex_valid[p] && i_ex_valid[q] && (i_ex_idx[p] == i_ex_idx[q]))
                  $fatal(1, "stq: two pipes write the same entry");
         for (int c = 0; c < DISP_W; c++)
            if ((CMT_W'(c) < i_commit_num) && (st_q[cmt_ptr_q + IDX_W'(c)] != E_DONE))
               $fatal(1, "stq: commit of an entry that is not DONE");
      end
   end
`endif

endmodule

// File: tb/tb_msrh_stq_pq.sv
module tb_msrh_stq_pq;

   logic              i_clk = 1'b0;
   logic              i_reset_n;
   logic [1:0]        i_disp_valid;
   logic [1:0][7:0]   i_disp_tag;
   logic              o_disp_ready;
   logic [1:0][3:0]   o_disp_idx;
   logic [1:0]        i_ex_valid;
   logic [1:0][3:0]   i_ex_idx;
   logic [1:0][55:0]  i_ex_paddr;
   logic [1:0][1:0]   i_ex_size;
   logic [1:0][63:0]  i_ex_data;
   logic [1:0]        o_done_valid;
   logic [1:0][7:0]   o_done_tag;
   logic [1:0]        i_commit_num;
   logic              i_flush;
   logic              o_l1d_req_valid;
   logic              i_l1d_req_ready;
   logic [55:0]       o_l1d_req_paddr;
   logic [127:0]      o_l1d_req_data;
   logic [15:0]       o_l1d_req_be;
   logic              i_l1d_resp_valid;
   logic              i_l1d_resp_hit;
   logic              i_refill_done;
   logic              o_empty;

   msrh_stq_pq dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n),
      .i_disp_valid(i_disp_valid), .i_disp_tag(i_disp_tag),
      .o_disp_ready(o_disp_ready), .o_disp_idx(o_disp_idx),
      .i_ex_valid(i_ex_valid), .i_ex_idx(i_ex_idx), .i_ex_paddr(i_ex_paddr),
      .i_ex_size(i_ex_size), .i_ex_data(i_ex_data),
      .o_done_valid(o_done_valid), .o_done_tag(o_done_tag),
      .i_commit_num(i_commit_num), .i_flush(i_flush),
      .o_l1d_req_valid(o_l1d_req_valid), .i_l1d_req_ready(i_l1d_req_ready),
      .o_l1d_req_paddr(o_l1d_req_paddr), .o_l1d_req_data(o_l1d_req_data),
      .o_l1d_req_be(o_l1d_req_be), .i_l1d_resp_valid(i_l1d_resp_valid),
      .i_l1d_resp_hit(i_l1d_resp_hit), .i_refill_done(i_refill_done),
      .o_empty(o_empty)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [55:0]  paddr;
      logic [127:0] data;
      logic [15:0]  be;
   } l1d_exp_t;

   logic [7:0] done_q[$];
   l1d_exp_t   l1d_q[$];
   int         n_pass = 0;
   int         n_total = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
   endtask

   // Monitor: compares every done report and every accepted L1D request
   // against the head of its expectation queue.
   always @(negedge i_clk) begin
      if (i_reset_n) begin
         for (int p = 0; p < 2; p++)
            if (o_done_valid[p]) begin
               if (done_q.size() == 0) chk("done_unexpected", {7'd0, p[0]}, 8'hFF);
               else chk("done_tag", o_done_tag[p], done_q.pop_front());
            end
         if (o_l1d_req_valid && i_l1d_req_ready) begin
            if (l1d_q.size() == 0) chk("l1d_unexpected", o_l1d_req_paddr, '1);
            else begin
               l1d_exp_t e;
               e = l1d_q.pop_front();
               chk("l1d_paddr", o_l1d_req_paddr, e.paddr);
               chk("l1d_data", o_l1d_req_data, e.data);
               chk("l1d_be", o_l1d_req_be, e.be);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic clr_in();
      i_disp_valid = '0; i_disp_tag = '0; i_ex_valid = '0; i_ex_idx = '0;
      i_ex_paddr = '0; i_ex_size = '0; i_ex_data = '0; i_commit_num = '0;
      i_flush = 0; i_l1d_req_ready = 0; i_l1d_resp_valid = 0;
      i_l1d_resp_hit = 0; i_refill_done = 0;
   endtask

   task automatic push_l1d(input logic [55:0] pa, input logic [127:0] d, input logic [15:0] be);
      l1d_exp_t e;
      e.paddr = pa; e.data = d; e.be = be;
      l1d_q.push_back(e);
   endtask

   task automatic wait_req();
      int n = 0;
      while (!o_l1d_req_valid && n < 30) begin tick(); n++; end
      chk("req_valid_wait", o_l1d_req_valid, 1);
   endtask

   task automatic accept();
      i_l1d_req_ready = 1; tick(); i_l1d_req_ready = 0;
   endtask

   task automatic respond(input logic hit);
      i_l1d_resp_valid = 1; i_l1d_resp_hit = hit; tick();
      i_l1d_resp_valid = 0; i_l1d_resp_hit = 0;
   endtask

   task automatic ex1(input int p, input logic [3:0] idx, input logic [55:0] pa,
                      input logic [1:0] sz, input logic [63:0] d);
      i_ex_valid[p] = 1; i_ex_idx[p] = idx; i_ex_paddr[p] = pa;
      i_ex_size[p] = sz; i_ex_data[p] = d;
   endtask

   function automatic logic [55:0] fill_pa(input int m);
      return 56'h4000 + 56'(8 * m);
   endfunction
   function automatic logic [63:0] fill_d(input int m);
      return {32'hC0DE0000 | 32'(m), 32'h5A5A0000 | 32'(m)};
   endfunction

   initial begin
      logic [3:0] b;
      i_reset_n = 0;
      clr_in();
      repeat (3) tick();
      i_reset_n = 1;
      tick();

      // Reset state
      chk("rst_disp_ready", o_disp_ready, 1);
      chk("rst_empty", o_empty, 1);
      chk("rst_req_valid", o_l1d_req_valid, 0);
      chk("rst_req_be", o_l1d_req_be, 0);
      chk("rst_done_valid", o_done_valid, 0);
      chk("rst_disp_idx", o_disp_idx, 8'h10);

      // Capture into a FREE entry is ignored
      ex1(0, 4'd5, 56'h100, 2'd0, 64'h1); tick(); clr_in();
      chk("ex_free_no_done", o_done_valid, 0);

      // Two stores, capture on both pipes
      i_disp_valid = 2'b11; i_disp_tag[0] = 8'h10; i_disp_tag[1] = 8'h11;
      chk("disp_idx0", o_disp_idx[0], 0);
      chk("disp_idx1", o_disp_idx[1], 1);
      tick(); clr_in();
      chk("empty_after_disp", o_empty, 0);
      ex1(0, 4'd0, 56'h1003, 2'd1, 64'hABCD);
      ex1(1, 4'd1, 56'h2000, 2'd3, 64'h1122334455667788);
      done_q.push_back(8'h10); done_q.push_back(8'h11);
      tick(); clr_in();

      // Commit one, hit path
      push_l1d(56'h1000, {2{64'h000000ABCD000000}}, 16'h0018);
      i_commit_num = 1; tick(); clr_in();
      chk("req_not_before_T2", o_l1d_req_valid, 0);
      tick();
      chk("req_at_T2", o_l1d_req_valid, 1);
      accept(); respond(1);

      // Miss, refill, replay with identical payload
      push_l1d(56'h2000, {2{64'h1122334455667788}}, 16'h00FF);
      i_commit_num = 1; tick(); clr_in();
      wait_req(); accept(); respond(0);
      for (int i = 0; i < 3; i++) begin
         chk("refill_wait_no_req", o_l1d_req_valid, 0);
         tick();
      end
      push_l1d(56'h2000, {2{64'h1122334455667788}}, 16'h00FF);
      i_refill_done = 1; tick(); clr_in();
      chk("replay_req", o_l1d_req_valid, 1);
      accept(); respond(1);
      chk("empty_after_two", o_empty, 1);

      // Request held while not ready
      i_disp_valid = 2'b01; i_disp_tag[0] = 8'h12;
      chk("disp_idx_stall", o_disp_idx[0], 2);
      tick(); clr_in();
      ex1(1, 4'd2, 56'h300A, 2'd2, 64'hDEADBEEF);
      done_q.push_back(8'h12);
      tick(); clr_in();
      i_commit_num = 1; tick(); clr_in();
      wait_req();
      for (int i = 0; i < 5; i++) begin
         chk("stall_valid", o_l1d_req_valid, 1);
         chk("stall_paddr", o_l1d_req_paddr, 56'h3000);
         chk("stall_be", o_l1d_req_be, 16'h3C00);
         chk("stall_data", o_l1d_req_data, {2{64'h0000DEADBEEF0000}});
         tick();
      end
      push_l1d(56'h3000, {2{64'h0000DEADBEEF0000}}, 16'h3C00);
      accept(); respond(1);

      // Fill all 16 entries starting at index 3, wrapping 15 -> 0
      for (int j = 0; j < 8; j++) begin
         i_disp_valid = 2'b11;
         i_disp_tag[0] = 8'(8'h20 + 2 * j); i_disp_tag[1] = 8'(8'h21 + 2 * j);
         if (j == 6) begin
            chk("wrap_idx0", o_disp_idx[0], 15);
            chk("wrap_idx1", o_disp_idx[1], 0);
         end
         tick(); clr_in();
         if (j == 6) chk("ready_free2", o_disp_ready, 1);
      end
      chk("ready_full", o_disp_ready, 0);
      for (int j = 0; j < 8; j++) begin
         b = 4'(3 + 2 * j);
         ex1(0, b, fill_pa(2 * j), 2'd3, fill_d(2 * j));
         ex1(1, b + 4'd1, fill_pa(2 * j + 1), 2'd3, fill_d(2 * j + 1));
         done_q.push_back(8'(8'h20 + 2 * j)); done_q.push_back(8'(8'h21 + 2 * j));
         tick(); clr_in();
      end

      // Drain two: one free keeps ready low, two frees raise it
      push_l1d(56'h4000, {2{fill_d(0)}}, 16'h00FF);
      push_l1d(56'h4000, {2{fill_d(1)}}, 16'hFF00);
      i_commit_num = 2; tick(); clr_in();
      wait_req(); accept(); respond(1);
      chk("ready_free1", o_disp_ready, 0);
      wait_req(); accept(); respond(1);
      chk("ready_free2_after_drain", o_disp_ready, 1);

      // Commit one with flush and a dropped dispatch in the same cycle
      push_l1d(56'h4010, {2{fill_d(2)}}, 16'h00FF);
      i_commit_num = 1; i_flush = 1; i_disp_valid = 2'b01; i_disp_tag[0] = 8'h99;
      tick(); clr_in();
      chk("flush_empty", o_empty, 0);
      chk("flush_alloc_ptr", o_disp_idx[0], 6);
      chk("flush_ready", o_disp_ready, 1);
      wait_req(); accept(); respond(1);
      chk("flush_drained_empty", o_empty, 1);

      // Reset in the middle of a request
      i_disp_valid = 2'b01; i_disp_tag[0] = 8'h40;
      chk("pre_rst_idx", o_disp_idx[0], 6);
      tick(); clr_in();
      ex1(0, 4'd6, 56'h5000, 2'd0, 64'h77);
      done_q.push_back(8'h40);
      tick(); clr_in();
      i_commit_num = 1; tick(); clr_in();
      wait_req();
      #2 i_reset_n = 0;
      #1;
      chk("midrst_req_valid", o_l1d_req_valid, 0);
      chk("midrst_req_paddr", o_l1d_req_paddr, 0);
      chk("midrst_ready", o_disp_ready, 1);
      chk("midrst_empty", o_empty, 1);
      tick();
      i_reset_n = 1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("post_rst_no_replay", o_l1d_req_valid, 0);
      end
      chk("post_rst_idx", o_disp_idx[0], 0);

      chk("done_q_drained", 32'(done_q.size()), 0);
      chk("l1d_q_drained", 32'(l1d_q.size()), 0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
